// File: rtl/wave_pkg.sv
// Shared state and mode encodings for the duty-cycle waveform sequencer.
package wave_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RAMP_UP,
        ST_HOLD_TOP,
        ST_RAMP_DOWN,
        ST_HOLD_BOT,
        ST_FIXED
    } wave_state_t;

    localparam logic [1:0] MODE_TRIANGLE = 2'd0;
    localparam logic [1:0] MODE_SAW_UP   = 2'd1;
    localparam logic [1:0] MODE_SAW_DOWN = 2'd2;
    localparam logic [1:0] MODE_FIXED    = 2'd3;

    function automatic wave_state_t start_state(input logic [1:0] m);
        case (m)
            MODE_SAW_DOWN: return ST_RAMP_DOWN;
            MODE_FIXED:    return ST_FIXED;
            default:       return ST_RAMP_UP;
        endcase
    endfunction

endpackage

// File: rtl/step_prescaler.sv
// Step-rate divider: tick is high while the count sits at DIV-1; clr holds the count at 0.
// Latency: tick combinational from the count register; no backpressure.
module step_prescaler #(
    parameter int unsigned DIV = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);
    localparam int unsigned     CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]   LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n || clr || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/duty_wave_sequencer.sv
// Duty-word generator for the PWM stage: triangle/saw/fixed profiles stepped on prescaler ticks.
// Latency: all outputs registered, one clk after the deciding edge; no backpressure, runs while enable=1.
module duty_wave_sequencer
    import wave_pkg::*;
#(
    parameter int unsigned DUTY_W     = 4,
    parameter int unsigned STEP_DIV   = 1_000_000,
    parameter int unsigned HOLD_STEPS = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [1:0]        mode,
    input  logic [DUTY_W-1:0] fixed_duty,
    output logic [DUTY_W-1:0] dutyc,
    output logic              dutyc_stb,
    output logic              ramp_dir,
    output logic              period_done
);
    localparam logic [DUTY_W-1:0] DUTY_MAX  = '1;
    localparam int unsigned       HOLD_W    = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = (HOLD_STEPS > 0) ? HOLD_W'(HOLD_STEPS - 1) : '0;

    wave_state_t       state_q, state_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [1:0]        mode_q, mode_d;
    logic              pd_d, pd_q, stb_q, dir_q;
    logic              restart, tick, presc_clr;

    assign presc_clr = (state_q == ST_IDLE) || !enable;

    step_prescaler #(.DIV(STEP_DIV)) u_presc (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (presc_clr),
        .tick  (tick)
    );

    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        hold_d  = hold_q;
        mode_d  = mode_q;
        pd_d    = 1'b0;
        restart = 1'b0;
        if (!enable) begin
            state_d = ST_IDLE;
            duty_d  = '0;
            hold_d  = '0;
        end else if (state_q == ST_IDLE) begin
            restart = 1'b1;
        end else if (tick) begin
            case (state_q)
                ST_RAMP_UP: begin
                    if (mode_q == MODE_SAW_UP && duty_q == DUTY_MAX) begin
                        pd_d    = 1'b1;
                        restart = 1'b1;
                    end else if (duty_q != DUTY_MAX) begin
                        duty_d = duty_q + 1'b1;
                        if (mode_q == MODE_TRIANGLE && duty_q == DUTY_MAX - 1'b1) begin
                            state_d = (HOLD_STEPS == 0) ? ST_RAMP_DOWN : ST_HOLD_TOP;
                        end
                    end
                end
                ST_HOLD_TOP: begin
                    if (hold_q == HOLD_LAST) begin
                        hold_d  = '0;
                        state_d = ST_RAMP_DOWN;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                ST_RAMP_DOWN: begin
                    if (duty_q == '0) begin
                        pd_d    = 1'b1;
                        restart = 1'b1;
                    end else begin
                        duty_d = duty_q - 1'b1;
                        // Triangle without dwell completes its period on the step that lands on 0.
                        if (mode_q == MODE_TRIANGLE && duty_q == DUTY_W'(1)) begin
                            if (HOLD_STEPS == 0) begin
                                pd_d    = 1'b1;
                                restart = 1'b1;
                            end else begin
                                state_d = ST_HOLD_BOT;
                            end
                        end
                    end
                end
                ST_HOLD_BOT: begin
                    if (hold_q == HOLD_LAST) begin
                        pd_d    = 1'b1;
                        restart = 1'b1;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                ST_FIXED: restart = 1'b1;
                default: ;
            endcase
        end

        // Mode is only re-sampled here, so mid-period mode changes have no effect.
        if (restart) begin
            mode_d  = mode;
            state_d = start_state(mode);
            hold_d  = '0;
            case (mode)
                MODE_SAW_DOWN: duty_d = DUTY_MAX;
                MODE_FIXED:    duty_d = fixed_duty;
                default:       duty_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            duty_q  <= '0;
            hold_q  <= '0;
            mode_q  <= MODE_TRIANGLE;
            pd_q    <= 1'b0;
            stb_q   <= 1'b0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
            hold_q  <= hold_d;
            mode_q  <= mode_d;
            pd_q    <= pd_d;
            stb_q   <= (duty_d != duty_q);
            dir_q   <= (state_d == ST_RAMP_UP) || (state_d == ST_HOLD_TOP);
        end
    end

    assign dutyc       = duty_q;
    assign dutyc_stb   = stb_q;
    assign ramp_dir    = dir_q;
    assign period_done = pd_q;

endmodule

// File: tb/tb_duty_wave_sequencer.sv
// Bench for duty_wave_sequencer: random timing/values checked against a tick-indexed waveform model.
module tb_duty_wave_sequencer;
    import wave_pkg::*;

    localparam int M = 15;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en_a, en_b;
    logic [1:0] mode_a, mode_b;
    logic [3:0] fix_a, fix_b;
    logic [3:0] duty_a, duty_b;
    logic       stb_a, stb_b, dir_a, dir_b, pd_a, pd_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    duty_wave_sequencer #(.DUTY_W(4), .STEP_DIV(4), .HOLD_STEPS(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .enable(en_a), .mode(mode_a), .fixed_duty(fix_a),
        .dutyc(duty_a), .dutyc_stb(stb_a), .ramp_dir(dir_a), .period_done(pd_a)
    );

    duty_wave_sequencer #(.DUTY_W(4), .STEP_DIV(1), .HOLD_STEPS(0)) u_fast (
        .clk(clk), .rst_n(rst_n), .enable(en_b), .mode(mode_b), .fixed_duty(fix_b),
        .dutyc(duty_b), .dutyc_stb(stb_b), .ramp_dir(dir_b), .period_done(pd_b)
    );

    // Waveform value after t ticks since the period start, from the profile shape.
    function automatic int tri_val(input int t, input int h);
        int p;
        p = t % (2*M + 2*h);
        if (p <= M) return p;
        if (p <= M + h) return M;
        if (p <= 2*M + h) return 2*M + h - p;
        return 0;
    endfunction

    function automatic int wave_val(input logic [1:0] m, input int t, input int h);
        if (m == MODE_SAW_UP)   return t % 16;
        if (m == MODE_SAW_DOWN) return M - (t % 16);
        return tri_val(t, h);
    endfunction

    function automatic int wave_per(input logic [1:0] m, input int h);
        return (m == MODE_TRIANGLE) ? 2*M + 2*h : 16;
    endfunction

    function automatic bit wave_dir(input logic [1:0] m, input int t, input int h);
        if (m == MODE_SAW_UP)   return 1'b1;
        if (m == MODE_SAW_DOWN) return 1'b0;
        return (t % (2*M + 2*h)) < (M + h);
    endfunction

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle();
        en_a = 1'b0;
        en_b = 1'b0;
        step_clk();
        step_clk();
    endtask

    task automatic test_reset();
        logic [6:0] got;
        rst_n = 1'b0; en_a = 1'b1; mode_a = MODE_TRIANGLE; fix_a = 4'd7;
        en_b = 1'b1; mode_b = MODE_SAW_DOWN; fix_b = 4'd0;
        for (int i = 0; i < 3; i++) begin
            step_clk();
            got = {duty_a, stb_a, pd_a, dir_a};
            total++;
            if (got !== 7'd0) begin bad++; $display("FAIL reset_a cyc=%0d got=%b want=0000000", i, got); end
            got = {duty_b, stb_b, pd_b, dir_b};
            total++;
            if (got !== 7'd0) begin bad++; $display("FAIL reset_b cyc=%0d got=%b want=0000000", i, got); end
        end
        en_b = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step_clk();
            got = {duty_a, stb_a, pd_a, dir_a};
            total++;
            if (got !== 7'b0000_001) begin bad++; $display("FAIL reset_release cyc=%0d got=%b want=0000001", i, got); end
        end
        go_idle();
    endtask

    task automatic test_triangle();
        int v, pv, t, nstb, npd;
        logic [6:0] got, exp;
        repeat ($urandom_range(1, 5)) step_clk();
        mode_a = MODE_TRIANGLE; en_a = 1'b1; pv = 0; nstb = 0; npd = 0;
        for (int n = 0; n < 2*136 + 8; n++) begin
            step_clk();
            t = n / 4;
            v = wave_val(MODE_TRIANGLE, t, 2);
            exp = {4'(v), v != pv, (n % 4 == 0) && t > 0 && (t % 34 == 0), wave_dir(MODE_TRIANGLE, t, 2)};
            got = {duty_a, stb_a, pd_a, dir_a};
            total++;
            if (got !== exp) begin bad++; $display("FAIL triangle n=%0d got=%b want=%b", n, got, exp); end
            if (n >= 1 && n <= 136) begin nstb += int'(stb_a); npd += int'(pd_a); end
            pv = v;
        end
        total++;
        if (nstb != 30) begin bad++; $display("FAIL tri_stb_count got=%0d want=30", nstb); end
        total++;
        if (npd != 1) begin bad++; $display("FAIL tri_pd_count got=%0d want=1", npd); end
        go_idle();
    endtask

    task automatic test_saw_fast();
        int v, pv;
        logic [6:0] got, exp;
        mode_b = MODE_SAW_UP; en_b = 1'b1; pv = 0;
        for (int n = 0; n < 40; n++) begin
            step_clk();
            v = n % 16;
            exp = {4'(v), v != pv, n > 0 && (n % 16 == 0), 1'b1};
            got = {duty_b, stb_b, pd_b, dir_b};
            total++;
            if (got !== exp) begin bad++; $display("FAIL saw_fast n=%0d got=%b want=%b", n, got, exp); end
            pv = v;
        end
        go_idle();
    endtask

    task automatic test_mode_change();
        int v, pv, t, sw;
        bit pde, dire;
        logic [6:0] got, exp;
        sw = $urandom_range(28, 31);
        mode_a = MODE_TRIANGLE; en_a = 1'b1; pv = 0;
        for (int n = 0; n < 136 + 80; n++) begin
            step_clk();
            t = n / 4;
            if (t < 34) begin
                v = tri_val(t, 2); pde = 1'b0; dire = wave_dir(MODE_TRIANGLE, t, 2);
            end else begin
                v = M - ((t - 34) % 16); pde = (n % 4 == 0) && ((t - 34) % 16 == 0); dire = 1'b0;
            end
            exp = {4'(v), v != pv, pde, dire};
            got = {duty_a, stb_a, pd_a, dir_a};
            total++;
            if (got !== exp) begin bad++; $display("FAIL mode_change n=%0d got=%b want=%b", n, got, exp); end
            pv = v;
            if (n == sw) mode_a = MODE_SAW_DOWN;
        end
        go_idle();
    endtask

    task automatic test_fixed();
        int v, pv, ev, ts;
        logic [3:0] fcur;
        bit pde, dire;
        logic [6:0] got, exp;
        fix_a = 4'd9; mode_a = MODE_FIXED; en_a = 1'b1; pv = 0; ev = 0;
        for (int n = 0; n < 90; n++) begin
            fcur = fix_a;
            step_clk();
            if (n < 44) begin
                if (n % 4 == 0) ev = int'(fcur);
                v = ev; pde = 1'b0; dire = 1'b0;
            end else begin
                ts = (n - 44) / 4;
                v = ts % 16; pde = (n % 4 == 0) && ts > 0 && (ts % 16 == 0); dire = 1'b1;
            end
            exp = {4'(v), v != pv, pde, dire};
            got = {duty_a, stb_a, pd_a, dir_a};
            total++;
            if (got !== exp) begin bad++; $display("FAIL fixed n=%0d got=%b want=%b", n, got, exp); end
            pv = v;
            if (n == 1) fix_a = 4'd3;
            else if (n > 4 && n < 40 && $urandom_range(0, 2) == 0) fix_a = 4'($urandom_range(0, 15));
            if (n == 40) mode_a = MODE_SAW_UP;
        end
        go_idle();
    endtask

    task automatic test_enable_drop();
        int v, pv, t, drop;
        logic [6:0] got, exp;
        drop = $urandom_range(84, 86);
        mode_a = MODE_TRIANGLE; en_a = 1'b1; pv = 0;
        for (int n = 0; n <= drop; n++) begin
            step_clk();
            t = n / 4;
            v = tri_val(t, 2);
            exp = {4'(v), v != pv, 1'b0, wave_dir(MODE_TRIANGLE, t, 2)};
            got = {duty_a, stb_a, pd_a, dir_a};
            total++;
            if (got !== exp) begin bad++; $display("FAIL drop_run n=%0d got=%b want=%b", n, got, exp); end
            pv = v;
        end
        en_a = 1'b0;
        step_clk();
        got = {duty_a, stb_a, pd_a, dir_a};
        total++;
        if (got !== 7'b0000_100) begin bad++; $display("FAIL drop_edge got=%b want=0000100", got); end
        for (int i = 0; i < 3; i++) begin
            step_clk();
            got = {duty_a, stb_a, pd_a, dir_a};
            total++;
            if (got !== 7'd0) begin bad++; $display("FAIL drop_idle cyc=%0d got=%b want=0000000", i, got); end
        end
        en_a = 1'b1; pv = 0;
        for (int n = 0; n < 12; n++) begin
            step_clk();
            t = n / 4;
            v = tri_val(t, 2);
            exp = {4'(v), v != pv, 1'b0, 1'b1};
            got = {duty_a, stb_a, pd_a, dir_a};
            total++;
            if (got !== exp) begin bad++; $display("FAIL drop_restart n=%0d got=%b want=%b", n, got, exp); end
            pv = v;
        end
        go_idle();
    endtask

    task automatic test_reset_mid();
        logic [6:0] got;
        mode_a = MODE_SAW_DOWN; en_a = 1'b1;
        repeat ($urandom_range(8, 60)) step_clk();
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step_clk();
            got = {duty_a, stb_a, pd_a, dir_a};
            total++;
            if (got !== 7'd0) begin bad++; $display("FAIL reset_mid cyc=%0d got=%b want=0000000", i, got); end
        end
        en_a = 1'b0;
        rst_n = 1'b1;
        step_clk();
    endtask

    task automatic test_random();
        int v, pv, t, len, per;
        logic [1:0] m;
        logic [6:0] got, exp;
        for (int it = 0; it < 4; it++) begin
            m = 2'($urandom_range(0, 2));
            len = $urandom_range(40, 200);
            per = wave_per(m, 2);
            mode_a = m; en_a = 1'b1; pv = 0;
            for (int n = 0; n < len; n++) begin
                step_clk();
                t = n / 4;
                v = wave_val(m, t, 2);
                exp = {4'(v), v != pv, (n % 4 == 0) && t > 0 && (t % per == 0), wave_dir(m, t, 2)};
                got = {duty_a, stb_a, pd_a, dir_a};
                total++;
                if (got !== exp) begin bad++; $display("FAIL random m=%0d n=%0d got=%b want=%b", m, n, got, exp); end
                pv = v;
            end
            en_a = 1'b0;
            step_clk();
            exp = {4'd0, pv != 0, 1'b0, 1'b0};
            got = {duty_a, stb_a, pd_a, dir_a};
            total++;
            if (got !== exp) begin bad++; $display("FAIL random_drop m=%0d got=%b want=%b", m, got, exp); end
            go_idle();
        end
    endtask

    initial begin
        test_reset();
        test_triangle();
        test_saw_fast();
        test_mode_change();
        test_fixed();
        test_enable_drop();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
